// File: rtl/spio_spinn2aer_mapper.sv
// Turns outbound SpiNNaker multicast packets back into AER events and drives an
// external AER receiver with an active-low 4-phase req/ack handshake.
module spio_spinn2aer_mapper #(
    parameter int PKT_BITS  = 72,
    parameter int VKEY_BITS = 16,
    parameter int MODE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MODE_BITS-1:0] vmode,
    input  logic [VKEY_BITS-1:0] vkey,
    input  logic [PKT_BITS-1:0]  opkt_data,
    input  logic                 opkt_vld,
    output logic                 opkt_rdy,
    output logic [15:0]          oaer_data,
    output logic                 oaer_req,
    input  logic                 oaer_ack,
    output logic [7:0]           parity_err_cnt,
    output logic [7:0]           key_miss_cnt
);

    // state | meaning
    // IDLE  | ready for a packet, req released
    // REQ   | event presented, req low, waiting for synchronized ack low
    // WACK  | req released, waiting for synchronized ack high
    typedef enum logic [1:0] {IDLE, REQ, WACK} state_t;

    localparam logic [MODE_BITS-1:0] MODE_RET_64   = MODE_BITS'(1);
    localparam logic [MODE_BITS-1:0] MODE_RET_32   = MODE_BITS'(2);
    localparam logic [MODE_BITS-1:0] MODE_RET_16   = MODE_BITS'(3);
    localparam logic [MODE_BITS-1:0] MODE_COCHLEA  = MODE_BITS'(4);
    localparam logic [MODE_BITS-1:0] MODE_DIRECT   = MODE_BITS'(5);

    state_t      state, state_nxt;
    logic        ack_meta, ack_s;
    logic        req_nxt;
    logic [15:0] data_nxt;
    logic        accept, parity_ok, key_ok;
    logic        perr_inc, kmiss_inc;
    logic [15:0] coord, mapped;

    assign opkt_rdy  = (state == IDLE);
    assign accept    = opkt_vld && opkt_rdy;
    assign parity_ok = ^opkt_data[39:0];
    assign key_ok    = (opkt_data[39:24] == vkey);
    assign coord     = opkt_data[23:8];

    // Undo the input-side mapping; 127-n is a plain 7-bit inversion.
    always_comb begin
        logic [6:0] nx, ny;
        nx     = coord[6:0];
        ny     = coord[13:7];
        mapped = 16'h0000;
        case (vmode)
            MODE_RET_64: begin
                nx = {coord[5:0], 1'b0};
                ny = {coord[11:6], 1'b0};
            end
            MODE_RET_32: begin
                nx = {coord[4:0], 2'b00};
                ny = {coord[9:5], 2'b00};
            end
            MODE_RET_16: begin
                nx = {coord[3:0], 3'b000};
                ny = {coord[7:4], 3'b000};
            end
            default: begin
                nx = coord[6:0];
                ny = coord[13:7];
            end
        endcase
        if (vmode == MODE_COCHLEA)
            mapped = {coord[15], 5'b00000, coord[1:0], coord[7:2], coord[11], 1'b0};
        else if (vmode == MODE_DIRECT)
            mapped = coord;
        else
            mapped = {coord[15], 7'd127 - nx, 7'd127 - ny, coord[14]};
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = oaer_req;
        data_nxt  = oaer_data;
        perr_inc  = 1'b0;
        kmiss_inc = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!parity_ok) begin
                        perr_inc = 1'b1;
                    end else if (!key_ok) begin
                        kmiss_inc = 1'b1;
                    end else begin
                        data_nxt  = mapped;
                        req_nxt   = 1'b0;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (!ack_s) begin
                    req_nxt   = 1'b1;
                    state_nxt = WACK;
                end
            end
            WACK: begin
                if (ack_s)
                    state_nxt = IDLE;
            end
            default: begin
                req_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            oaer_req  <= 1'b1;
            oaer_data <= 16'h0000;
            ack_meta  <= 1'b1;
            ack_s     <= 1'b1;
        end else begin
            state     <= state_nxt;
            oaer_req  <= req_nxt;
            oaer_data <= data_nxt;
            ack_meta  <= oaer_ack;
            ack_s     <= ack_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_cnt <= 8'h00;
            key_miss_cnt   <= 8'h00;
        end else begin
            if (perr_inc && parity_err_cnt != 8'hFF)
                parity_err_cnt <= parity_err_cnt + 8'd1;
            if (kmiss_inc && key_miss_cnt != 8'hFF)
                key_miss_cnt <= key_miss_cnt + 8'd1;
        end
    end

endmodule

// File: doc/spio_spinn2aer_mapper.md
# spio_spinn2aer_mapper

Converts SpiNNaker multicast packets back into AER events and drives an external AER receiver (for example, a display or an actuator) using the active-low 4-phase req/ack handshake. The block sits on the outbound packet path of the SpiNNaker-AER interface board and undoes the input-side coordinate mapping, including the 90° clockwise retina rotation. Packets with a bad parity bit or a non-matching virtual key are dropped and counted.

## Interface
- PKT_BITS, 72, packet width: payload [71:40], routing key [39:8], control [7:1], parity [0].
- VKEY_BITS, 16, virtual-key width, compared against key[39:24].
- MODE_BITS, 3, mode width. Encoding: 0 RET_128, 1 RET_64, 2 RET_32, 3 RET_16, 4 COCHLEA, 5 DIRECT; 6–7 behave as RET_128.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- vmode  in  MODE_BITS  mapping mode, sampled at packet acceptance.
- vkey  in  VKEY_BITS  virtual key to accept.
- opkt_data  in  PKT_BITS  packet.
- opkt_vld  in  1  packet valid.
- opkt_rdy  out  1  ready; asserted exactly when the state is IDLE.
- oaer_data  out  16  AER event.
- oaer_req  out  1  request, active LOW.
- oaer_ack  in  1  acknowledge, active LOW, asynchronous to clk.
- parity_err_cnt  out  8  count of dropped bad-parity packets, saturates at 255.
- key_miss_cnt  out  8  count of dropped key-mismatch packets, saturates at 255.

## Operation
- States are IDLE, REQ and WACK.
- A packet is accepted on any edge where opkt_vld && opkt_rdy.
- Parity check: the packet is good when ^opkt_data[39:0] == 1 (odd parity).
- Drop rules at acceptance:
  - Bad parity: increment parity_err_cnt; stay in IDLE.
  - Good parity and key[39:24] != vkey: increment key_miss_cnt; stay in IDLE.
  - Bad parity takes precedence, so only one counter increments per packet.
  - The payload and control fields are ignored.
- Good packet at acceptance: register oaer_data from the mapped coordinates c = key[23:8], drive oaer_req <= 0, and go to REQ.
- Mapping from c to oaer_data (pol = c[15], sgn = c[14]):
  - RET_128: nx = c[6:0], ny = c[13:7].
  - RET_64: nx = {c[5:0],1'b0}, ny = {c[11:6],1'b0}.
  - RET_32: nx = {c[4:0],2'b00}, ny = {c[9:5],2'b00}.
  - RET_16: nx = {c[3:0],3'b000}, ny = {c[7:4],3'b000}.
  - All retina modes: oaer_data = {pol, 127-nx, 127-ny, sgn}, i.e. old Y in bits [14:8] and old X in bits [7:1]. The subtraction is 7-bit and never wraps, because nx and ny are at most 127.
  - COCHLEA: oaer_data = {c[15], 5'b0, c[1:0], c[7:2], c[11], 1'b0}.
  - DIRECT: oaer_data = c.
- oaer_ack passes through a 2-flop synchronizer to produce ack_s. Both flops reset to 1.
- REQ: when ack_s == 0, set oaer_req <= 1 and go to WACK.
- WACK: when ack_s == 1, go to IDLE.
- oaer_data changes only at acceptance of a good packet. It therefore stays stable from req assertion until after ack is released.

## Timing
- Reset values:
  - state = IDLE, so opkt_rdy = 1.
  - oaer_req = 1.
  - oaer_data = 0.
  - Both counters = 0.
  - Sync flops = 1.
- Acceptance edge to oaer_req low: visible immediately after that same edge (0 cycles of added latency).
- oaer_ack falling to oaer_req rising: 3 clk edges (2 for synchronization, 1 for the register).
- oaer_ack rising to opkt_rdy high: 3 clk edges.
- Minimum spacing between accepted good packets is 2 cycles plus the handshake time.
- Dropped packets: one per cycle, with opkt_rdy held high throughout.
- Counters saturate: at 255, further drops leave the value at 255.
- oaer_ack falling while in IDLE or WACK is ignored. The block does not advance until it sees the required level in the current state.
- Reset mid-handshake (rst asserted in REQ or WACK): oaer_req goes to 1 asynchronously, the state returns to IDLE and any pending event is lost.

## Test plan
- Good packet, RET_128, vkey = 0x0200, opkt_data = {32'd0, 32'h02003F7E, 8'h00} (parity good) -> oaer_req low with oaer_data = 0x0102. Device ack low -> req high 3 edges later. Ack high -> opkt_rdy high 3 edges later.
- Same key with bit 0 flipped -> no req; parity_err_cnt = 1; opkt_rdy stays 1.
- Key 0x03003F7E with correct parity -> no req; key_miss_cnt = 1.
- COCHLEA, key 0x020088A7 with correct parity -> oaer_data = 0x83A6.
- Back-to-back good packets with opkt_vld held high and a slow device (ack delay 10 cycles) -> opkt_rdy low throughout REQ/WACK, second event issued only after the first handshake completes, and oaer_data stable while req is low.
- 300 bad-parity packets -> parity_err_cnt = 255. Then rst pulsed while in REQ -> oaer_req = 1 and both counters = 0 immediately.
